// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the port-A arbiter in front of duel_mem: widths, read owner and
// the in-flight read tag.
package cpu_mem_pkg;

   localparam int MEM_ADDR_W = 11;
   localparam int MEM_DATA_W = 32;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } mem_owner_e;

   typedef struct packed {
      logic       valid;
      mem_owner_e owner;
   } mem_tag_t;

   localparam mem_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_IF};

   function automatic mem_tag_t make_tag(input logic valid, input mem_owner_e owner);
      mem_tag_t t;
      t.valid = valid;
      t.owner = owner;
      return t;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and RAM port-A signals around mem_port_arbiter.
// slave is the arbiter's view, master the surrounding pipeline/RAM view.
interface mem_port_arbiter_if
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  ls_req, ls_we, ls_addr, ls_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_addr, mem_wren, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output ls_req, ls_we, ls_addr, ls_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_addr, mem_wren, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter_tag_pipe.sv
// mem_tag_pipe: DEPTH-stage shift register carrying read tags alongside the RAM read
// latency; synchronous active-low clear drops every tag in flight.
module mem_tag_pipe
   import cpu_mem_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  mem_tag_t tag_in,
   output mem_tag_t tag_out
);

   mem_tag_t stage_r [DEPTH];

   // Advance tags one stage per cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= TAG_IDLE;
         end
      end else begin
         stage_r[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares duel_mem port A between fetch and load/store, one access per
// cycle, and routes read data back to its owner. MEM_ARB_LS_PRIORITY_EN selects fixed LS priority.
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W   = MEM_ADDR_W,
   parameter int DATA_W   = MEM_DATA_W,
   parameter int READ_LAT = 1          // legal 1..4
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.slave  bus
);

   mem_owner_e        last_winner_r;
   logic [ADDR_W-1:0] addr_hold_r;
   logic [DATA_W-1:0] wdata_hold_r;

   logic              pick_ls_s;
   logic              if_gnt_s;
   logic              ls_gnt_s;
   logic              any_gnt_s;
   logic              wr_s;
   logic [ADDR_W-1:0] gnt_addr_s;
   mem_tag_t          tag_in_s;
   mem_tag_t          tag_out_s;
   logic              if_rvalid_s;
   logic              ls_rvalid_s;

   // Winner selection; grants are suppressed while reset is held
   always_comb begin
      pick_ls_s = 1'b0;
`ifdef MEM_ARB_LS_PRIORITY_EN
      pick_ls_s = bus.ls_req;
`else
      if (bus.ls_req && bus.if_req) begin
         pick_ls_s = (last_winner_r == OWN_IF);
      end else begin
         pick_ls_s = bus.ls_req;
      end
`endif
      if_gnt_s   = rst_n & bus.if_req & ~pick_ls_s;
      ls_gnt_s   = rst_n & pick_ls_s;
      any_gnt_s  = if_gnt_s | ls_gnt_s;
      wr_s       = ls_gnt_s & bus.ls_we;
      gnt_addr_s = ls_gnt_s ? bus.ls_addr : bus.if_addr;
      tag_in_s   = make_tag(if_gnt_s | (ls_gnt_s & ~bus.ls_we), ls_gnt_s ? OWN_LS : OWN_IF);
   end

   // Round-robin history and the idle-cycle values of the RAM address/data bus
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_winner_r <= OWN_LS;
         addr_hold_r   <= '0;
         wdata_hold_r  <= '0;
      end else begin
         if (any_gnt_s) begin
            last_winner_r <= ls_gnt_s ? OWN_LS : OWN_IF;
            addr_hold_r   <= gnt_addr_s;
         end else begin
            last_winner_r <= last_winner_r;
            addr_hold_r   <= addr_hold_r;
         end
         if (wr_s) begin
            wdata_hold_r <= bus.ls_wdata;
         end else begin
            wdata_hold_r <= wdata_hold_r;
         end
      end
   end

   mem_tag_pipe #(
      .DEPTH (READ_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (tag_in_s),
      .tag_out (tag_out_s)
   );

   // Return path: the tag leaving the pipe names which side owns mem_rdata this cycle
   always_comb begin
      if_rvalid_s = rst_n & tag_out_s.valid & (tag_out_s.owner == OWN_IF);
      ls_rvalid_s = rst_n & tag_out_s.valid & (tag_out_s.owner == OWN_LS);
   end

   assign bus.if_gnt    = if_gnt_s;
   assign bus.ls_gnt    = ls_gnt_s;
   assign bus.mem_addr  = !rst_n ? '0 : (any_gnt_s ? gnt_addr_s : addr_hold_r);
   assign bus.mem_wren  = wr_s;
   assign bus.mem_wdata = !rst_n ? '0 : (wr_s ? bus.ls_wdata : wdata_hold_r);
   assign bus.if_rvalid = if_rvalid_s;
   assign bus.ls_rvalid = ls_rvalid_s;
   assign bus.if_rdata  = if_rvalid_s ? bus.mem_rdata : '0;
   assign bus.ls_rdata  = ls_rvalid_s ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with READ_LAT 1, 2 and 3, each
// in front of a behavioural port-A RAM model with matching read latency.
module tb_mem_port_arbiter;
   import cpu_mem_pkg::*;

`ifdef MEM_ARB_LS_PRIORITY_EN
   localparam bit LS_PRIO = 1'b1;
`else
   localparam bit LS_PRIO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   logic        ld_en;
   logic [10:0] ld_addr;
   logic [31:0] ld_data;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(11), .DATA_W(32)) b1 ();
   mem_port_arbiter_if #(.ADDR_W(11), .DATA_W(32)) b2 ();
   mem_port_arbiter_if #(.ADDR_W(11), .DATA_W(32)) b3 ();

   mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .READ_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .READ_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
   mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .READ_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

   logic [31:0] ram1 [2048];
   logic [31:0] ram2 [2048];
   logic [31:0] ram3 [2048];
   logic [31:0] rd1;
   logic [31:0] rd2 [2];
   logic [31:0] rd3 [3];

   // RAM models: write on the edge, read data READ_LAT cycles after the address
   always @(posedge clk) begin
      if (ld_en) begin
         ram1[ld_addr] <= ld_data;
         ram2[ld_addr] <= ld_data;
         ram3[ld_addr] <= ld_data;
      end else begin
         if (b1.mem_wren) ram1[b1.mem_addr] <= b1.mem_wdata;
         if (b2.mem_wren) ram2[b2.mem_addr] <= b2.mem_wdata;
         if (b3.mem_wren) ram3[b3.mem_addr] <= b3.mem_wdata;
      end
      rd1    <= ram1[b1.mem_addr];
      rd2[0] <= ram2[b2.mem_addr];
      rd2[1] <= rd2[0];
      rd3[0] <= ram3[b3.mem_addr];
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
   end

   assign b1.mem_rdata = rd1;
   assign b2.mem_rdata = rd2[1];
   assign b3.mem_rdata = rd3[2];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [10:0] a, input logic [31:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      next_cycle();
      ld_en   = 1'b0;
   endtask

   task automatic idle_all();
      b1.if_req = 1'b0; b1.ls_req = 1'b0; b1.ls_we = 1'b0;
      b2.if_req = 1'b0; b2.ls_req = 1'b0; b2.ls_we = 1'b0;
      b3.if_req = 1'b0; b3.ls_req = 1'b0; b3.ls_we = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      logic exp_ls [4];
      logic exp_rv_if, exp_rv_ls;

      rst_n = 1'b0;
      ld_en = 1'b0; ld_addr = 11'd0; ld_data = 32'd0;
      idle_all();
      b1.if_addr = 11'd0; b1.ls_addr = 11'd0; b1.ls_wdata = 32'd0;
      b2.if_addr = 11'd0; b2.ls_addr = 11'd0; b2.ls_wdata = 32'd0;
      b3.if_addr = 11'd0; b3.ls_addr = 11'd0; b3.ls_wdata = 32'd0;
      next_cycle();

      load_word(11'd0,  32'h1000_0000);
      load_word(11'd1,  32'h1000_0001);
      load_word(11'd2,  32'h1000_0002);
      load_word(11'd5,  32'hE3A0_0001);
      load_word(11'd7,  32'h0000_0777);
      load_word(11'd10, 32'h0000_00AA);

      // Reset state with a pending request that must not be granted
      b1.if_req = 1'b1; b1.if_addr = 11'd5;
      @(negedge clk);
      check_eq("rst_if_gnt",    32'(b1.if_gnt),    32'd0);
      check_eq("rst_ls_gnt",    32'(b1.ls_gnt),    32'd0);
      check_eq("rst_if_rvalid", 32'(b1.if_rvalid), 32'd0);
      check_eq("rst_ls_rvalid", 32'(b1.ls_rvalid), 32'd0);
      check_eq("rst_mem_wren",  32'(b1.mem_wren),  32'd0);
      check_eq("rst_mem_addr",  32'(b1.mem_addr),  32'd0);
      check_eq("rst_if_rdata",  b1.if_rdata,       32'd0);
      next_cycle();
      b1.if_req = 1'b0;
      do_reset();

      // Single IF read, READ_LAT=1
      b1.if_req = 1'b1; b1.if_addr = 11'd5;
      @(negedge clk);
      check_eq("t1_c0_if_gnt",   32'(b1.if_gnt),   32'd1);
      check_eq("t1_c0_mem_addr", 32'(b1.mem_addr), 32'd5);
      check_eq("t1_c0_if_rvalid", 32'(b1.if_rvalid), 32'd0);
      next_cycle();
      b1.if_req = 1'b0;
      @(negedge clk);
      check_eq("t1_c1_if_rvalid", 32'(b1.if_rvalid), 32'd1);
      check_eq("t1_c1_if_rdata",  b1.if_rdata,       32'hE3A0_0001);
      check_eq("t1_c1_ls_rvalid", 32'(b1.ls_rvalid), 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("t1_c2_if_rvalid", 32'(b1.if_rvalid), 32'd0);
      check_eq("t1_c2_ls_rvalid", 32'(b1.ls_rvalid), 32'd0);
      next_cycle();

      // Both requesting for four cycles right after reset
      do_reset();
      for (int k = 0; k < 4; k++) exp_ls[k] = LS_PRIO ? 1'b1 : ((k % 2) == 1);
      for (int k = 0; k < 5; k++) begin
         b1.if_req  = (k < 4); b1.if_addr = 11'd5;
         b1.ls_req  = (k < 4); b1.ls_we   = 1'b0; b1.ls_addr = 11'd10;
         @(negedge clk);
         if (k < 4) begin
            check_eq($sformatf("t2_c%0d_if_gnt", k), 32'(b1.if_gnt), 32'(!exp_ls[k]));
            check_eq($sformatf("t2_c%0d_ls_gnt", k), 32'(b1.ls_gnt), 32'(exp_ls[k]));
         end else begin
            check_eq("t2_c4_gnt_none", 32'({b1.if_gnt, b1.ls_gnt}), 32'd0);
         end
         exp_rv_if = (k >= 1) && !exp_ls[(k >= 1) ? k - 1 : 0];
         exp_rv_ls = (k >= 1) &&  exp_ls[(k >= 1) ? k - 1 : 0];
         check_eq($sformatf("t2_c%0d_if_rvalid", k), 32'(b1.if_rvalid), 32'(exp_rv_if));
         check_eq($sformatf("t2_c%0d_ls_rvalid", k), 32'(b1.ls_rvalid), 32'(exp_rv_ls));
         check_eq($sformatf("t2_c%0d_if_rdata", k), b1.if_rdata, exp_rv_if ? 32'hE3A0_0001 : 32'd0);
         check_eq($sformatf("t2_c%0d_ls_rdata", k), b1.ls_rdata, exp_rv_ls ? 32'h0000_00AA : 32'd0);
         next_cycle();
      end

      // Store then load of the same address in the next cycle
      b1.ls_req = 1'b1; b1.ls_we = 1'b1; b1.ls_addr = 11'd20; b1.ls_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check_eq("t3_c0_ls_gnt",    32'(b1.ls_gnt),   32'd1);
      check_eq("t3_c0_mem_wren",  32'(b1.mem_wren), 32'd1);
      check_eq("t3_c0_mem_wdata", b1.mem_wdata,     32'hDEAD_BEEF);
      check_eq("t3_c0_mem_addr",  32'(b1.mem_addr), 32'd20);
      next_cycle();
      b1.ls_we = 1'b0; b1.ls_wdata = 32'd0;
      @(negedge clk);
      check_eq("t3_c1_ls_gnt",    32'(b1.ls_gnt),    32'd1);
      check_eq("t3_c1_mem_wren",  32'(b1.mem_wren),  32'd0);
      check_eq("t3_c1_ls_rvalid", 32'(b1.ls_rvalid), 32'd0);
      next_cycle();
      b1.ls_req = 1'b0;
      @(negedge clk);
      check_eq("t3_c2_ls_rvalid", 32'(b1.ls_rvalid), 32'd1);
      check_eq("t3_c2_ls_rdata",  b1.ls_rdata,       32'hDEAD_BEEF);
      check_eq("t3_c2_mem_wren",  32'(b1.mem_wren),  32'd0);
      check_eq("t3_c2_if_rvalid", 32'(b1.if_rvalid), 32'd0);
      next_cycle();

      // READ_LAT=3: back-to-back reads of 0, 1, 2
      for (int k = 0; k < 7; k++) begin
         b3.if_req  = (k < 3);
         b3.if_addr = 11'(k);
         @(negedge clk);
         check_eq($sformatf("t4_c%0d_if_gnt", k), 32'(b3.if_gnt), 32'(k < 3));
         check_eq($sformatf("t4_c%0d_if_rvalid", k), 32'(b3.if_rvalid), 32'((k >= 3) && (k <= 5)));
         check_eq($sformatf("t4_c%0d_if_rdata", k), b3.if_rdata,
                  ((k >= 3) && (k <= 5)) ? 32'h1000_0000 + 32'(k - 3) : 32'd0);
         next_cycle();
      end

      // READ_LAT=2: reset lands while a read is in flight
      b2.if_req = 1'b1; b2.if_addr = 11'd7;
      @(negedge clk);
      check_eq("t5_c0_if_gnt", 32'(b2.if_gnt), 32'd1);
      next_cycle();
      rst_n = 1'b0;
      b2.ls_req = 1'b1; b2.ls_we = 1'b0; b2.ls_addr = 11'd10;
      @(negedge clk);
      check_eq("t5_c1_gnts",    32'({b2.if_gnt, b2.ls_gnt}),       32'd0);
      check_eq("t5_c1_wren",    32'(b2.mem_wren),                  32'd0);
      check_eq("t5_c1_addr",    32'(b2.mem_addr),                  32'd0);
      check_eq("t5_c1_rvalids", 32'({b2.if_rvalid, b2.ls_rvalid}), 32'd0);
      check_eq("t5_c1_if_rdata", b2.if_rdata,                      32'd0);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("t5_c2_if_gnt",  32'(b2.if_gnt),                    32'(!LS_PRIO));
      check_eq("t5_c2_ls_gnt",  32'(b2.ls_gnt),                    32'(LS_PRIO));
      check_eq("t5_c2_rvalids", 32'({b2.if_rvalid, b2.ls_rvalid}), 32'd0);
      next_cycle();
      b2.if_req = 1'b0; b2.ls_req = 1'b0;
      @(negedge clk);
      check_eq("t5_c3_rvalids", 32'({b2.if_rvalid, b2.ls_rvalid}), 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("t5_c4_if_rvalid", 32'(b2.if_rvalid), 32'(!LS_PRIO));
      check_eq("t5_c4_ls_rvalid", 32'(b2.ls_rvalid), 32'(LS_PRIO));
      check_eq("t5_c4_if_rdata",  b2.if_rdata, LS_PRIO ? 32'd0 : 32'h0000_0777);
      check_eq("t5_c4_ls_rdata",  b2.ls_rdata, LS_PRIO ? 32'h0000_00AA : 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("t5_c5_rvalids", 32'({b2.if_rvalid, b2.ls_rvalid}), 32'd0);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
